// File: rtl/rv32i_defs.sv
// rtl/rv32i_defs.sv - shared RV32I widths and instruction loader types
package rv32i_defs;

    localparam int InstructionSize = 32;
    localparam int BytesPerInstr   = 4;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_RECV,
        LD_WRITE,
        LD_DONE
    } loader_state_t;

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs little-endian bytes into one instruction word
module byte_word_packer
    import rv32i_defs::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [7:0]                 din,
    output logic [InstructionSize-1:0] word,
    output logic                       full
);

    localparam int IdxW = $clog2(BytesPerInstr);

    logic [IdxW-1:0]            idx_q, idx_d;
    logic [InstructionSize-1:0] word_q, word_d;

    // The push that lands in the top lane completes the word this cycle.
    assign full = push && (idx_q == IdxW'(BytesPerInstr - 1));
    assign word = word_q;

    // Clear zeroes every lane so a partial word leaves unfilled lanes at 0x00.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear) begin
            word_d = '0;
            idx_d  = '0;
        end else if (push) begin
            word_d[{idx_q, 3'b000} +: 8] = din;
            idx_d                        = idx_q + IdxW'(1);
        end
    end

    // Lane index and buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte stream to instruction memory loader with core reset hold
module instr_mem_loader
    import rv32i_defs::*;
#(
    parameter  int NUM_INSTR = 32,
    localparam int ADDR_SIZE = $clog2(NUM_INSTR * 4)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       flush,
    input  logic                       byte_valid,
    input  logic [7:0]                 byte_data,
    output logic                       byte_ready,
    output logic                       mem_we,
    output logic [ADDR_SIZE-1:0]       mem_addr,
    output logic [InstructionSize-1:0] mem_wdata,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_SIZE-2:0]       word_count,
    output logic                       core_rst_hold
);

    localparam int WidxW = ADDR_SIZE - 2;
    localparam int WcW   = ADDR_SIZE - 1;

    loader_state_t    state_q, state_d;
    logic [WidxW-1:0] word_idx_q, word_idx_d;
    logic [WcW-1:0]   word_count_q, word_count_d;
    logic             flush_pend_q, flush_pend_d;
    logic             have_bytes_q, have_bytes_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hold_q, hold_d;

    logic             accept;
    logic             start_load;
    logic             last_word;
    logic             pk_clear;
    logic             pk_full;
    logic [InstructionSize-1:0] pk_word;

    assign byte_ready = (state_q == LD_RECV);
    assign mem_we     = (state_q == LD_WRITE);
    assign accept     = byte_valid && byte_ready;
    assign start_load = start && ((state_q == LD_IDLE) || (state_q == LD_DONE));
    assign last_word  = (word_idx_q == WidxW'(NUM_INSTR - 1));
    // The buffer is emptied when a load begins and once its word has been written.
    assign pk_clear   = start_load || (state_q == LD_WRITE);

    byte_word_packer u_packer (
        .clk   (clk),
        .rst   (rst),
        .clear (pk_clear),
        .push  (accept),
        .din   (byte_data),
        .word  (pk_word),
        .full  (pk_full)
    );

    assign mem_addr      = {word_idx_q, 2'b00};
    assign mem_wdata     = pk_word;
    assign busy          = busy_q;
    assign done          = done_q;
    assign word_count    = word_count_q;
    assign core_rst_hold = hold_q;

    // Next-state logic: a byte in the same cycle as flush is taken before flush applies.
    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        word_count_d = word_count_q;
        flush_pend_d = flush_pend_q;
        have_bytes_d = have_bytes_q;
        case (state_q)
            LD_IDLE, LD_DONE: begin
                if (start) begin
                    state_d      = LD_RECV;
                    word_idx_d   = '0;
                    word_count_d = '0;
                    flush_pend_d = 1'b0;
                    have_bytes_d = 1'b0;
                end
            end
            LD_RECV: begin
                if (accept) begin
                    have_bytes_d = 1'b1;
                end
                if (pk_full) begin
                    state_d = LD_WRITE;
                    if (flush) begin
                        flush_pend_d = 1'b1;
                    end
                end else if (flush) begin
                    if (!have_bytes_q && !accept) begin
                        state_d = LD_DONE;
                    end else begin
                        flush_pend_d = 1'b1;
                        state_d      = LD_WRITE;
                    end
                end
            end
            LD_WRITE: begin
                word_idx_d   = word_idx_q + WidxW'(1);
                word_count_d = word_count_q + WcW'(1);
                have_bytes_d = 1'b0;
                flush_pend_d = 1'b0;
                state_d      = (last_word || flush_pend_q) ? LD_DONE : LD_RECV;
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the upcoming state so they line up with it.
    always_comb begin
        busy_d = (state_d == LD_RECV) || (state_d == LD_WRITE);
        done_d = (state_d == LD_DONE);
        hold_d = (state_d != LD_DONE);
    end

    // State, counters and status registers; reset aborts any load in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LD_IDLE;
            word_idx_q   <= '0;
            word_count_q <= '0;
            flush_pend_q <= 1'b0;
            have_bytes_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hold_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            word_count_q <= word_count_d;
            flush_pend_q <= flush_pend_d;
            have_bytes_q <= have_bytes_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            hold_q       <= hold_d;
        end
    end

endmodule
